// File: rtl/matmul_host_sequencer.sv
`default_nettype none
// matmul_host_sequencer: streams banked A/B operands into the multiplier BRAMs, runs it,
// then drains C through a 2-entry skid FIFO onto a valid/ready stream.  Rev 1.0
module matmul_host_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int M           = 3,
   parameter int K           = 3,
   parameter int N           = 3,
   parameter int N_BANKS     = 3,
   parameter int TIMEOUT_CYC = 1024,
   localparam int BA    = (M/N_BANKS*K > 0) ? $clog2(M/N_BANKS*K) : 1,
   localparam int BB    = (K*N/N_BANKS > 0) ? $clog2(K*N/N_BANKS) : 1,
   localparam int AW_A  = $clog2(N_BANKS) + BA,
   localparam int AW_B  = $clog2(N_BANKS) + BB,
   localparam int AW_C  = $clog2(M*N),
   localparam int ACC_W = 2*DATA_WIDTH + ((K > 1) ? $clog2(K) : 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_start,
   output logic                          busy,
   output logic                          job_done,
   output logic                          job_err,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [N_BANKS*DATA_WIDTH-1:0] s_data,
   output logic                          start_mult,
   input  logic                          mult_done,
   output logic                          en_a_brams,
   output logic                          we_a_brams,
   output logic [N_BANKS*AW_A-1:0]       addr_a_brams,
   output logic [N_BANKS*DATA_WIDTH-1:0] din_a_brams,
   output logic                          en_b_brams,
   output logic                          we_b_brams,
   output logic [N_BANKS*AW_B-1:0]       addr_b_brams,
   output logic [N_BANKS*DATA_WIDTH-1:0] din_b_brams,
   output logic                          read_en_c,
   output logic [AW_C-1:0]               read_addr_c,
   input  logic [ACC_W-1:0]              dout_c,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [ACC_W-1:0]              m_data,
   output logic                          m_last
);

   localparam int NBA = M/N_BANKS*K;
   localparam int NBB = K*N/N_BANKS;
   localparam int NW  = M*N;
   localparam int BW  = (BA > BB) ? BA : ((BB > 0) ? BB : 1);
   localparam int TW  = $clog2(TIMEOUT_CYC + 4);
   localparam int CW  = $clog2(NW + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_RUN    = 3'd3,
      S_READ_C = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [BW-1:0]      beat_q, beat_d;
   logic [TW-1:0]      run_cnt_q, run_cnt_d;
   logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
   logic               infl_q, infl_d;
   logic               infl_last_q, infl_last_d;
   logic [ACC_W-1:0]   fifo_data_q [2];
   logic [ACC_W-1:0]   fifo_data_d [2];
   logic [1:0]         fifo_last_q, fifo_last_d;
   logic [1:0]         fifo_cnt_q, fifo_cnt_d;
   logic               start_mult_q, start_mult_d;
   logic               busy_q, busy_d;
   logic               job_err_q, job_err_d;

   logic               a_wr, b_wr, pop, rd_issue;
   logic [2:0]         occ;

   assign s_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign a_wr     = s_valid && s_ready && (state_q == S_LOAD_A);
   assign b_wr     = s_valid && s_ready && (state_q == S_LOAD_B);
   assign m_valid  = (fifo_cnt_q != 2'd0);
   assign pop      = m_valid && m_ready;
   // A pop this cycle frees a slot, which is what sustains one word per cycle.
   assign occ      = 3'(infl_q) + 3'(fifo_cnt_q) - 3'(pop);
   assign rd_issue = (state_q == S_READ_C) && (rd_cnt_q != CW'(NW)) && (occ < 3'd2);

   assign m_data      = fifo_data_q[0];
   assign m_last      = m_valid && fifo_last_q[0];
   assign job_done    = pop && fifo_last_q[0];
   assign read_en_c   = rd_issue;
   assign read_addr_c = rd_issue ? AW_C'(rd_cnt_q) : '0;
   assign start_mult  = start_mult_q;
   assign busy        = busy_q;
   assign job_err     = job_err_q;

   assign en_a_brams  = a_wr;
   assign we_a_brams  = a_wr;
   assign din_a_brams = a_wr ? s_data : '0;
   assign en_b_brams  = b_wr;
   assign we_b_brams  = b_wr;
   assign din_b_brams = b_wr ? s_data : '0;

   for (genvar b = 0; b < N_BANKS; b++) begin : g_lane
      assign addr_a_brams[b*AW_A +: AW_A] = a_wr ? ((AW_A'(b) << BA) | AW_A'(beat_q)) : '0;
      assign addr_b_brams[b*AW_B +: AW_B] = b_wr ? ((AW_B'(b) << BB) | AW_B'(beat_q)) : '0;
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      run_cnt_d = run_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      job_err_d = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_start) begin
            state_d = S_LOAD_A;
            beat_d  = '0;
         end
         S_LOAD_A: if (a_wr) begin
            if (beat_q == BW'(NBA - 1)) begin
               state_d = S_LOAD_B;
               beat_d  = '0;
            end else beat_d = beat_q + 1'b1;
         end
         S_LOAD_B: if (b_wr) begin
            if (beat_q == BW'(NBB - 1)) begin
               state_d   = S_RUN;
               run_cnt_d = '0;
            end else beat_d = beat_q + 1'b1;
         end
         S_RUN: begin
            // The first two RUN cycles ignore mult_done so a level left over from a prior job cannot end this one.
            if ((run_cnt_q >= TW'(2)) && mult_done) begin
               state_d  = S_READ_C;
               rd_cnt_d = '0;
            end else if ((TIMEOUT_CYC != 0) && (run_cnt_q == TW'(TIMEOUT_CYC - 1))) begin
               state_d   = S_IDLE;
               job_err_d = 1'b1;
            end else if (run_cnt_q != '1) begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end
         S_READ_C: begin
            if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
            if (job_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      infl_d       = rd_issue;
      infl_last_d  = rd_issue && (rd_cnt_q == CW'(NW - 1));
      start_mult_d = (state_d == S_RUN);
      busy_d       = (state_d != S_IDLE);

      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      fifo_cnt_d  = fifo_cnt_q;
      case ({infl_q, pop})
         2'b10: begin
            if (fifo_cnt_q == 2'd0) begin
               fifo_data_d[0] = dout_c;
               fifo_last_d[0] = infl_last_q;
            end else begin
               fifo_data_d[1] = dout_c;
               fifo_last_d[1] = infl_last_q;
            end
            fifo_cnt_d = fifo_cnt_q + 2'd1;
         end
         2'b01: begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
            fifo_data_d[1] = '0;
            fifo_last_d[1] = 1'b0;
            fifo_cnt_d     = fifo_cnt_q - 2'd1;
         end
         2'b11: begin
            if (fifo_cnt_q == 2'd1) begin
               fifo_data_d[0] = dout_c;
               fifo_last_d[0] = infl_last_q;
            end else begin
               fifo_data_d[0] = fifo_data_q[1];
               fifo_last_d[0] = fifo_last_q[1];
               fifo_data_d[1] = dout_c;
               fifo_last_d[1] = infl_last_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         beat_q       <= '0;
         run_cnt_q    <= '0;
         rd_cnt_q     <= '0;
         infl_q       <= 1'b0;
         infl_last_q  <= 1'b0;
         fifo_data_q  <= '{default: '0};
         fifo_last_q  <= '0;
         fifo_cnt_q   <= '0;
         start_mult_q <= 1'b0;
         busy_q       <= 1'b0;
         job_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         run_cnt_q    <= run_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         infl_q       <= infl_d;
         infl_last_q  <= infl_last_d;
         fifo_data_q  <= fifo_data_d;
         fifo_last_q  <= fifo_last_d;
         fifo_cnt_q   <= fifo_cnt_d;
         start_mult_q <= start_mult_d;
         busy_q       <= busy_d;
         job_err_q    <= job_err_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/matmul_host_sequencer.md
Name: matmul_host_sequencer

Overview:
- Host-side driver for the matrix multiplier top level. It streams packed A and B operand beats into the banked A/B BRAMs through their Port A load interface, then drives start_mult and holds it until mult_done.
- After the run it reads all M*N results out of the C BRAM read port and presents them on a valid/ready output stream.
- It sits between the system bus/DMA and the multiplier top level, acting as the initiator of the multiplier's load/start/readout interface.

Parameters:
- DATA_WIDTH, 16, operand element width.
- M, 3, rows of A and C; must be divisible by N_BANKS.
- K, 3, columns of A and rows of B.
- N, 3, columns of B and C; must be divisible by N_BANKS.
- N_BANKS, 3, number of A/B BRAM banks (lanes per beat).
- TIMEOUT_CYC, 1024, maximum RUN cycles before error; 0 disables the timeout.
- Derived (localparam): BA = (M/N_BANKS*K>0 ? clog2(M/N_BANKS*K) : 1); BB = same form over K*N/N_BANKS; AW_A = clog2(N_BANKS)+BA; AW_B = clog2(N_BANKS)+BB; AW_C = clog2(M*N); ACC_W = 2*DATA_WIDTH+(K>1 ? clog2(K) : 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_start  in  1  one-cycle pulse; starts a job, honoured only in IDLE
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse when the last C word is accepted
- job_err  out  1  one-cycle pulse on RUN timeout
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat ready
- s_data  in  N_BANKS*DATA_WIDTH  operand beat; slice b goes to bank b
- start_mult  out  1  level to the multiplier; high only in RUN
- mult_done  in  1  multiplier completion
- en_a_brams, we_a_brams  out  1 each  A Port A enable and write enable
- addr_a_brams  out  N_BANKS*AW_A  per-lane A address
- din_a_brams  out  N_BANKS*DATA_WIDTH  per-lane A write data
- en_b_brams, we_b_brams  out  1 each  B Port A enable and write enable
- addr_b_brams  out  N_BANKS*AW_B  per-lane B address
- din_b_brams  out  N_BANKS*DATA_WIDTH  per-lane B write data
- read_en_c  out  1  C read enable
- read_addr_c  out  AW_C  C read address
- dout_c  in  ACC_W  C read data; valid exactly one cycle after read_en_c
- m_valid  out  1  result valid
- m_ready  in  1  result ready
- m_data  out  ACC_W  result word
- m_last  out  1  high with the final word (index M*N-1)

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge): state=IDLE. All outputs are 0, including buses.
  - Reset mid-job aborts immediately: start_mult, en_*, we_* and read_en_c drop the next cycle.
  - Buffered C data is discarded and no job_done is issued.
- States: IDLE, LOAD_A, LOAD_B, RUN, READ_C.
- IDLE -> LOAD_A on cmd_start; the beat counter clears.
- LOAD_A:
  - s_ready=1.
  - Each s_valid&&s_ready beat j (0..M/N_BANKS*K-1) drives, combinationally in the same cycle: en_a_brams=we_a_brams=1; lane b addr = {b[clog2(N_BANKS)-1:0], j[BA-1:0]}; lane b din = s_data slice b.
  - The last beat moves to LOAD_B.
- LOAD_B: identical to LOAD_A, using the B ports and K*N/N_BANKS beats; the last beat moves to RUN.
- Load bus idle values: en/we are 0 and the address/data buses are 0 whenever no beat is handshaken. s_ready=0 outside the LOAD states.
- RUN:
  - start_mult=1 from the first RUN cycle and held continuously.
  - mult_done is ignored in the first 2 RUN cycles, to mask a stale done level.
  - Afterwards, the first cycle with mult_done=1 moves to READ_C; start_mult is 0 from that next cycle.
  - Timeout: a RUN cycle counter reaching TIMEOUT_CYC pulses job_err, drops start_mult, and returns to IDLE with no readout.
- READ_C:
  - Issue read_en_c with read_addr_c = 0,1,...,M*N-1 in order.
  - A read issues only when (in-flight + buffered) < 2. This uses a 2-entry output FIFO, so no result is ever dropped under m_ready backpressure.
  - dout_c is captured the cycle after each read. m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last marks word M*N-1.
  - Full throughput: 1 word/cycle when m_ready is held high. First m_valid appears 2 cycles after READ_C entry (1 read latency + FIFO register).
  - The handshake of the m_last word pulses job_done the same cycle; the state returns to IDLE next cycle.
- A cmd_start while busy is ignored.
- Simultaneous FIFO push and pop are allowed and leave the occupancy unchanged.
- m_data/m_valid stay stable while m_valid && !m_ready.

Test Plan:
- Basic job (defaults 3/3/3/3): cmd_start; 3 A beats, 3 B beats with s_valid held -> writes to addr lanes {0,j},{1,j},{2,j} for j=0..2 with din matching s_data slices. start_mult rises in the cycle after the last B beat. With A=I and B=[1..9], m_data reads 1..9 in order, m_last on the 9th word, job_done asserted once.
- Gapped input: s_valid toggles 1/0 -> no BRAM write occurs in the 0 cycles, addresses stay contiguous, and the result is identical to the basic job.
- Backpressure: m_ready pattern 1,0,0,1,0,1... -> no lost or duplicated word, at most 2 reads outstanding+buffered, m_data stable while stalled.
- Stale done: mult_done held 1 before the job starts -> RUN still lasts at least 3 cycles and start_mult is high for at least 2 cycles.
- Timeout with TIMEOUT_CYC=16 and mult_done stuck 0 -> job_err pulses after 16 RUN cycles, start_mult drops, busy=0, and no read_en_c ever asserts.
- Reset mid-READ_C after 4 words -> all outputs are 0 the next cycle. A fresh job then completes correctly from word 0.
